// File: rtl/writeback_pkg.sv
// Shared writeback types, constants and helpers for the writeback arbiter slice.
package writeback_pkg;

    localparam int unsigned WB_ZERO_REG      = 0;
    localparam int unsigned WB_DEF_ADDR_BITS = 5;

    // Default-width result message; the top module builds its own with the configured widths.
    typedef struct packed {
        logic [WB_DEF_ADDR_BITS-1:0] waddr;
        logic [31:0]                 wdata;
        logic                        wen;
    } wb_msg_t;

    // Index width for a pipe select, never narrower than one bit.
    function automatic int unsigned wb_idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Execute-pipe result handshakes plus the regfile write/commit port of the writeback arbiter.
interface writeback_arbiter_if
    import writeback_pkg::*;
#(
    parameter int unsigned p_num_pipes = 2,
    parameter int unsigned p_addr_bits = 5,
    parameter type         t_entry     = logic [31:0]
);

    localparam int unsigned p_pipe_bits = wb_idx_bits(p_num_pipes);

    logic [p_num_pipes-1:0]                  ex_val;
    logic [p_num_pipes-1:0]                  ex_rdy;
    logic [p_num_pipes-1:0][p_addr_bits-1:0] ex_waddr;
    t_entry                                  ex_wdata [p_num_pipes];
    logic [p_num_pipes-1:0]                  ex_wen;

    logic [p_addr_bits-1:0] waddr;
    t_entry                 wdata;
    logic                   wen;
    logic                   commit_val;
    logic [p_pipe_bits-1:0] commit_pipe;

    modport master (
        output ex_val, ex_waddr, ex_wdata, ex_wen,
        input  ex_rdy, waddr, wdata, wen, commit_val, commit_pipe
    );

    modport slave (
        input  ex_val, ex_waddr, ex_wdata, ex_wen,
        output ex_rdy, waddr, wdata, wen, commit_val, commit_pipe
    );

endinterface

// File: rtl/wb_input_buffer.sv
// One-entry result buffer for a single execute pipe; accepts a new result while being drained.
module wb_input_buffer
    import writeback_pkg::*;
#(
    parameter type t_msg = wb_msg_t
) (
    input  logic clk,
    input  logic rst,
    input  logic val,
    input  t_msg msg_in,
    input  logic grant,
    input  logic skip,
    output logic rdy,
    output logic full,
    output t_msg msg
);

    logic full_q, full_d;
    t_msg msg_q, msg_d;
    logic load;

    assign rdy  = !full_q || grant;
    // A bypassed result is retired directly and must not also land in the buffer.
    assign load = val && rdy && !skip;

    always_comb begin
        full_d = full_q;
        msg_d  = msg_q;
        if (load) begin
            full_d = 1'b1;
            msg_d  = msg_in;
        end else if (grant) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            msg_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
        end
    end

    assign full = full_q;
    assign msg  = msg_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin serialisation of execute-pipe results onto the single regfile write port.
// Optional same-cycle bypass when idle: define WRITEBACK_ARB_BYPASS_EN.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int unsigned p_num_pipes = 2,
    parameter int unsigned p_num_regs  = 32,
    parameter type         t_entry     = logic [31:0]
) (
    input logic          clk,
    input logic          rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned p_addr_bits = $clog2(p_num_regs);
    localparam int unsigned p_pipe_bits = wb_idx_bits(p_num_pipes);

    typedef struct packed {
        logic [p_addr_bits-1:0] waddr;
        t_entry                 wdata;
        logic                   wen;
    } msg_t;

    msg_t                   in_msg  [p_num_pipes];
    msg_t                   buf_msg [p_num_pipes];
    logic [p_num_pipes-1:0] full, grant, skip, rdy;
    logic [p_pipe_bits-1:0] ptr_q, ptr_d, gnt_idx, sel_idx;
    logic                   gnt_any, sel_any;
    msg_t                   sel_msg;

    for (genvar i = 0; i < p_num_pipes; i++) begin : g_pipe
        assign in_msg[i] = '{waddr: bus.ex_waddr[i], wdata: bus.ex_wdata[i], wen: bus.ex_wen[i]};

        wb_input_buffer #(
            .t_msg (msg_t)
        ) u_buf (
            .clk    (clk),
            .rst    (rst),
            .val    (bus.ex_val[i]),
            .msg_in (in_msg[i]),
            .grant  (grant[i]),
            .skip   (skip[i]),
            .rdy    (rdy[i]),
            .full   (full[i]),
            .msg    (buf_msg[i])
        );
    end

    assign bus.ex_rdy = rdy;

    // First full buffer at or after the pointer; nothing retires while in reset.
    always_comb begin
        int unsigned cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (!rst) begin
            for (int unsigned off = 0; off < p_num_pipes; off++) begin
                cand = (32'(ptr_q) + off) % p_num_pipes;
                if (!gnt_any && full[p_pipe_bits'(cand)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = p_pipe_bits'(cand);
                end
            end
        end
        for (int unsigned i = 0; i < p_num_pipes; i++) begin
            grant[i] = gnt_any && (gnt_idx == p_pipe_bits'(i));
        end
    end

`ifdef WRITEBACK_ARB_BYPASS_EN
    logic                   byp_any;
    logic [p_pipe_bits-1:0] byp_idx;

    always_comb begin
        byp_any = !rst && !(|full) && $onehot(bus.ex_val);
        byp_idx = '0;
        for (int unsigned i = 0; i < p_num_pipes; i++) begin
            if (bus.ex_val[i]) begin
                byp_idx = p_pipe_bits'(i);
            end
        end
        skip = byp_any ? bus.ex_val : '0;
    end

    assign sel_any = gnt_any || byp_any;
    assign sel_idx = gnt_any ? gnt_idx : byp_idx;
    assign sel_msg = gnt_any ? buf_msg[gnt_idx] : in_msg[byp_idx];
`else
    assign skip    = '0;
    assign sel_any = gnt_any;
    assign sel_idx = gnt_idx;
    assign sel_msg = buf_msg[gnt_idx];
`endif

    always_comb begin
        bus.waddr       = '0;
        bus.wdata       = '0;
        bus.wen         = 1'b0;
        bus.commit_val  = 1'b0;
        bus.commit_pipe = '0;
        if (sel_any) begin
            bus.waddr       = sel_msg.waddr;
            bus.wdata       = sel_msg.wdata;
            // x0 results still retire, but never reach the regfile.
            bus.wen         = sel_msg.wen && (sel_msg.waddr != p_addr_bits'(WB_ZERO_REG));
            bus.commit_val  = 1'b1;
            bus.commit_pipe = sel_idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (sel_any) begin
            ptr_d = p_pipe_bits'((32'(sel_idx) + 1) % p_num_pipes);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a behavioural retirement model.
module tb_writeback_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    writeback_arbiter_if #(
        .p_num_pipes (N),
        .p_addr_bits (5),
        .t_entry     (logic [31:0])
    ) wb_if ();

    writeback_arbiter #(
        .p_num_pipes (N),
        .p_num_regs  (32),
        .t_entry     (logic [31:0])
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (wb_if)
    );

    // Model: each pipe holds at most one pending result; retire order is round-robin.
    logic        m_full [N];
    logic [4:0]  m_addr [N];
    logic [31:0] m_data [N];
    logic        m_wen  [N];
    int          rr;
    logic [31:0] rf [32];

    int          n_checks, n_fail;
    logic [N-1:0] acc;
    logic         obs_cval, obs_wen;
    logic [31:0]  obs_pipe, obs_wdata;
    logic [4:0]   obs_waddr;
    logic [N-1:0] obs_rdy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic we);
        wb_if.ex_val[i]   = v;
        wb_if.ex_waddr[i] = a;
        wb_if.ex_wdata[i] = d;
        wb_if.ex_wen[i]   = we;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, 1'b0);
    endtask

    // New offer only once the previous one was taken; otherwise hold it stable.
    task automatic drive_random(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!wb_if.ex_val[i] || acc[i]) begin
                if ($urandom_range(99) < pct)
                    drive(i, 1'b1, 5'($urandom), $urandom, 1'($urandom));
                else
                    drive(i, 1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic cycle();
        int           w, c;
        logic         byp;
        logic [N-1:0] exp_rdy;
        logic [4:0]   ea;
        logic [31:0]  ed;
        logic         ew;
        w   = -1;
        byp = 1'b0;
        if (!rst) begin
            for (int o = 0; o < N; o++) begin
                c = (rr + o) % N;
                if (w < 0 && m_full[c]) w = c;
            end
`ifdef WRITEBACK_ARB_BYPASS_EN
            if (w < 0 && $countones(wb_if.ex_val) == 1) begin
                byp = 1'b1;
                for (int i = 0; i < N; i++) if (wb_if.ex_val[i]) w = i;
            end
`endif
        end
        ea = '0; ed = '0; ew = 1'b0;
        if (w >= 0) begin
            if (byp) begin
                ea = wb_if.ex_waddr[w]; ed = wb_if.ex_wdata[w]; ew = wb_if.ex_wen[w];
            end else begin
                ea = m_addr[w]; ed = m_data[w]; ew = m_wen[w];
            end
        end
        for (int i = 0; i < N; i++) exp_rdy[i] = !m_full[i] || (!byp && w == i);

        @(negedge clk);
        obs_cval  = wb_if.commit_val;
        obs_pipe  = 32'(wb_if.commit_pipe);
        obs_rdy   = wb_if.ex_rdy;
        obs_wen   = wb_if.wen;
        obs_waddr = wb_if.waddr;
        obs_wdata = wb_if.wdata;
        check_eq("commit_val", 64'(obs_cval), 64'(w >= 0));
        check_eq("commit_pipe", 64'(obs_pipe), (w >= 0) ? 64'(w) : 64'd0);
        check_eq("waddr", 64'(obs_waddr), 64'(ea));
        check_eq("wdata", 64'(obs_wdata), 64'(ed));
        check_eq("wen", 64'(obs_wen), 64'(ew && ea != 0));
        if (!rst) check_eq("ex_rdy", 64'(obs_rdy), 64'(exp_rdy));
        acc = wb_if.ex_val & exp_rdy;

        @(posedge clk);
        if (obs_wen) rf[obs_waddr] = obs_wdata;
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            rr = 0;
        end else begin
            if (w >= 0) begin
                rr = (w + 1) % N;
                if (!byp) m_full[w] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i] && !(byp && w == i)) begin
                    m_full[i] = 1'b1;
                    m_addr[i] = wb_if.ex_waddr[i];
                    m_data[i] = wb_if.ex_wdata[i];
                    m_wen[i]  = wb_if.ex_wen[i];
                end
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr       = 0;
        acc      = '0;
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        reset_dut();
        cycle();
        check_eq("reset_rdy", 64'(obs_rdy), 64'(2'b11));
        check_eq("reset_cval", 64'(obs_cval), 64'd0);

        // Single pipe result reaches the regfile
        drive(0, 1'b1, 5'd1, 32'habcd, 1'b1);
        cycle();
        idle();
        cycle();
        check_eq("rf_x1", 64'(rf[1]), 64'h abcd);

        // Contention: pipe 0 first, pipe 1 blocked, then pipe 1
        reset_dut();
        drive(0, 1'b1, 5'd5, 32'hf00d, 1'b1);
        drive(1, 1'b1, 5'd6, 32'h1234, 1'b1);
        cycle();
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b1, 5'd9, 32'h0077, 1'b1);
        cycle();
        check_eq("cont_pipe0", 64'(obs_pipe), 64'd0);
        check_eq("cont_blocked", 64'(obs_rdy[1]), 64'd0);
        cycle();
        check_eq("cont_pipe1", 64'(obs_pipe), 64'd1);
        idle();
        cycle();
        cycle();

        // x0 and no-writeback results
        drive(0, 1'b1, 5'd0, 32'hbaad, 1'b1);
        cycle();
        idle();
        cycle();
        drive(1, 1'b1, 5'd7, 32'h1111, 1'b0);
        cycle();
        idle();
        cycle();
        check_eq("x0_kept", 64'(rf[0]), 64'd0);

        // Fairness under continuous offers
        reset_dut();
        for (int k = 0; k < 7; k++) begin
            drive_random(100);
            cycle();
            if (k > 0) begin
                check_eq("fair_cval", 64'(obs_cval), 64'd1);
                check_eq("fair_pipe", 64'(obs_pipe), 64'((k - 1) % 2));
            end
        end

        // Reset with both buffers full
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        cycle();
        check_eq("midrst_cval", 64'(obs_cval), 64'd0);
        check_eq("midrst_rdy", 64'(obs_rdy), 64'(2'b11));
        drive_random(100);
        cycle();
        drive_random(100);
        cycle();
        check_eq("midrst_ptr", 64'(obs_pipe), 64'd0);

`ifdef WRITEBACK_ARB_BYPASS_EN
        // Idle bypass, then pointer has moved past pipe 1
        reset_dut();
        drive(1, 1'b1, 5'd3, 32'h5678, 1'b1);
        cycle();
        check_eq("byp_wen", 64'(obs_wen), 64'd1);
        check_eq("byp_waddr", 64'(obs_waddr), 64'd3);
        drive(0, 1'b1, 5'd10, 32'h1, 1'b1);
        drive(1, 1'b1, 5'd11, 32'h2, 1'b1);
        cycle();
        idle();
        cycle();
        check_eq("byp_next", 64'(obs_pipe), 64'd0);
`endif

        // Random traffic with occasional resets
        idle();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(49) == 0);
            drive_random(55);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
